// File: rtl/req_encoder_pipe_pkg.sv
// Shared mode encodings and the one-hot test used by the request encoder.
package enc_pkg;

  localparam logic [1:0] ENC_ONEHOT = 2'b00;
  localparam logic [1:0] ENC_FIXED  = 2'b01;
  localparam logic [1:0] ENC_RROBIN = 2'b10;

  // Callers zero-extend narrower vectors; extra zero bits do not change the count.
  function automatic logic onehot_check(input logic [63:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/req_encoder_pipe_prio_pick.sv
// Combinational lowest-set-bit picker: zero latency, no state, no backpressure.
module prio_pick
  import enc_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0]         req,
  output logic                 found,
  output logic [$clog2(N)-1:0] index,
  output logic                 onehot
);

  localparam int IW = $clog2(N);

  logic [63:0] req_ext;

  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) index = i[IW-1:0];
    end
  end

  assign req_ext = 64'(req);
  assign found   = |req;
  assign onehot  = onehot_check(req_ext);

endmodule

// File: rtl/req_encoder_pipe.sv
// N-to-log2(N) request encoder with one-hot/fixed/round-robin modes; 1-cycle latency.
// Result register holds while out_valid & !out_ready; a new capture may replace it in the accept cycle.
module req_encoder_pipe
  import enc_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         req_ack,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_err,
  output logic                 out_multi
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] rr_ptr;
  logic [N-1:0]  rr_mask;
  logic [N-1:0]  req_masked;

  logic          all_found;
  logic [IW-1:0] all_index;
  logic          all_onehot;
  logic          msk_found;
  logic [IW-1:0] msk_index;
  logic          msk_onehot;

  logic [IW-1:0] win_index;
  logic          win_err;
  logic          win_multi;
  logic [N-1:0]  win_ack;
  logic          cap;

  assign rr_mask    = {N{1'b1}} << rr_ptr;
  assign req_masked = req & rr_mask;

  prio_pick #(.N(N)) u_pick_all (
    .req    (req),
    .found  (all_found),
    .index  (all_index),
    .onehot (all_onehot)
  );

  prio_pick #(.N(N)) u_pick_msk (
    .req    (req_masked),
    .found  (msk_found),
    .index  (msk_index),
    .onehot (msk_onehot)
  );

  // A masked vector can only be one-hot if it has a set bit.
  always_comb begin
    assert (!msk_onehot || msk_found);
  end

  always_comb begin
    win_index = all_index;
    win_err   = 1'b0;
    win_multi = all_found & ~all_onehot;
    win_ack   = {{(N-1){1'b0}}, 1'b1} << all_index;
    case (mode)
      ENC_ONEHOT: begin
        if (!all_onehot) begin
          win_index = '0;
          win_err   = 1'b1;
          win_multi = 1'b1;
          win_ack   = '0;
        end
      end
      ENC_RROBIN: begin
        // Nothing at or above the pointer: wrap to the lowest request overall.
        if (msk_found) begin
          win_index = msk_index;
          win_ack   = {{(N-1){1'b0}}, 1'b1} << msk_index;
        end
      end
      default: ;
    endcase
  end

  assign cap = enable & (|req) & (~out_valid | out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_err   <= 1'b0;
      out_multi <= 1'b0;
      req_ack   <= '0;
      rr_ptr    <= '0;
    end else begin
      req_ack <= '0;
      if (cap) begin
        out_valid <= 1'b1;
        out_index <= win_index;
        out_err   <= win_err;
        out_multi <= win_multi;
        req_ack   <= win_ack;
        if (mode == ENC_RROBIN) rr_ptr <= win_index + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
